// File: rtl/add_shared_arbiter.sv
// add_shared_arbiter: one parallel-prefix adder shared by NumReq requesters.
// Requests are picked round-robin, registered into an operand stage, summed
// by the shared Add, registered into a result stage and returned tagged with
// the requester index. The file also holds the Add prefix adder itself.

// Add: S = A + B mod 2^width built from a generate/propagate prefix network.
// speed selects the carry network: 0 ripple, 1 Brent-Kung, 2 Sklansky.
// All three networks compute the same group-generate prefix, so the sum is
// bit-identical whichever network is chosen.
module Add #(
    parameter int width = 8,
    parameter int speed = 2
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] s
);

    localparam int Levels = (width > 1) ? $clog2(width) : 1;

    logic [width-1:0] gen;   // bit generate
    logic [width-1:0] prop;  // bit propagate (also the carry-free sum)
    logic [width-1:0] gpre;  // group generate over bits [0..i]

    assign gen  = a & b;
    assign prop = a ^ b;

    // Carry into bit i is the group generate of bits [0..i-1]; no carry-in.
    assign s = prop ^ {gpre[width-2:0], 1'b0};

    generate
        if (speed == 0) begin : g_ripple
            logic [width-1:0] gg;

            // Serial carry chain: each bit absorbs the prefix of the bit below.
            always_comb begin
                gg = gen;
                for (int i = 1; i < width; i++) begin
                    gg[i] = gen[i] | (prop[i] & gg[i-1]);
                end
                gpre = gg;
            end
        end else if (speed == 1) begin : g_brent_kung
            logic [width-1:0] gg;
            logic [width-1:0] pp;

            // Up-sweep builds power-of-two blocks, down-sweep fills the gaps.
            // Within one level no node reads a node updated on that level,
            // so in-place updates are safe.
            always_comb begin
                gg = gen;
                pp = prop;
                for (int l = 0; l < Levels; l++) begin
                    for (int i = 0; i < width; i++) begin
                        if (((i + 1) % (1 << (l + 1))) == 0) begin
                            gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                            pp[i] = pp[i] & pp[i - (1 << l)];
                        end
                    end
                end
                for (int l = Levels - 2; l >= 0; l--) begin
                    for (int i = 0; i < width; i++) begin
                        if ((i >= (1 << (l + 1))) &&
                            (((i + 1) % (1 << (l + 1))) == (1 << l))) begin
                            gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                            pp[i] = pp[i] & pp[i - (1 << l)];
                        end
                    end
                end
                gpre = gg;
            end
        end else begin : g_sklansky
            logic [width-1:0] gg;
            logic [width-1:0] pp;

            // Divide-and-conquer: on level l every node whose bit l is set
            // combines with the top node of the lower half of its block.
            always_comb begin
                gg = gen;
                pp = prop;
                for (int l = 0; l < Levels; l++) begin
                    for (int i = 0; i < width; i++) begin
                        if (((i >> l) % 2) == 1) begin
                            gg[i] = gg[i] | (pp[i] & gg[((i >> l) << l) - 1]);
                            pp[i] = pp[i] & pp[((i >> l) << l) - 1];
                        end
                    end
                end
                gpre = gg;
            end
        end
    endgenerate

endmodule

// Handshake rules used on both sides of the pipeline: a transfer happens on
// a rising edge where valid and ready are both high. A producer holding valid
// keeps its payload stable until that edge. Ready may depend combinationally
// on valid, never the other way round. Here req_ready_o depends on
// req_valid_i and res_ready_i; res_valid_o is purely registered.
module add_shared_arbiter #(
    parameter  int width  = 8,
    parameter  int speed  = 2,
    parameter  int NumReq = 4,
    localparam int IdW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic [NumReq*width-1:0] A_i,
    input  logic [NumReq*width-1:0] B_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [width-1:0]        S_o,
    output logic [IdW-1:0]          res_id_o,
    output logic                    busy_o
);

    // Round-robin pointer: the requester searched first this cycle.
    logic [IdW-1:0]    ptr;
    logic [IdW-1:0]    ptr_next;

    // Arbiter result.
    logic [NumReq-1:0] grant;
    logic [IdW-1:0]    gnt_id;
    logic              found;
    int                cand;

    // Operands of the granted requester.
    logic [width-1:0]  sel_a;
    logic [width-1:0]  sel_b;

    // Stage 1: operand register.
    logic              s1_valid;
    logic [width-1:0]  s1_a;
    logic [width-1:0]  s1_b;
    logic [IdW-1:0]    s1_id;

    // Stage 2: result register.
    logic              s2_valid;
    logic [width-1:0]  s2_sum;
    logic [IdW-1:0]    s2_id;

    // Pipeline control.
    logic              s1_adv;
    logic              s1_take;
    logic              xfer;
    logic [width-1:0]  sum;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < NumReq; k++) begin
            cand = (int'(ptr) + k) % NumReq;
            for (int r = 0; r < NumReq; r++) begin
                if (!found && (r == cand) && req_valid_i[r]) begin
                    grant[r] = 1'b1;
                    gnt_id   = IdW'(r);
                    found    = 1'b1;
                end
            end
        end
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int r = 0; r < NumReq; r++) begin
            if (grant[r]) begin
                sel_a = A_i[r*width +: width];
                sel_b = B_i[r*width +: width];
            end
        end
    end

    // Stage 1 moves on when stage 2 is empty or is being drained this edge;
    // stage 1 can load when it is empty or moving on.
    assign s1_adv  = s1_valid & (~s2_valid | res_ready_i);
    assign s1_take = ~s1_valid | s1_adv;

    // No accept is offered while reset is asserted, so reset always wins.
    assign req_ready_o = rst_i ? '0 : (grant & {NumReq{s1_take}});
    assign xfer        = |(req_valid_i & req_ready_o);

    // Next pointer is the slot after the winner, wrapping at NumReq.
    assign ptr_next = (gnt_id == IdW'(NumReq - 1)) ? '0 : gnt_id + 1'b1;

    // Pointer advances only when a request actually transfers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= ptr_next;
        end
    end

    // Operand stage: capture the granted operands and the owner's index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else begin
            if (s1_take) begin
                s1_valid <= xfer;
            end
            if (xfer) begin
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_id <= gnt_id;
            end
        end
    end

    // The shared adder sits between the two registers.
    Add #(
        .width(width),
        .speed(speed)
    ) u_add (
        .a(s1_a),
        .b(s1_b),
        .s(sum)
    );

    // Result stage: load from stage 1, or empty out when the consumer takes it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_id    <= '0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_sum   <= sum;
            s2_id    <= s1_id;
        end else if (res_ready_i && s2_valid) begin
            s2_valid <= 1'b0;
        end
    end

    assign res_valid_o = s2_valid;
    assign S_o         = s2_sum;
    assign res_id_o    = s2_id;
    assign busy_o      = s1_valid | s2_valid;

endmodule

// File: tb/tb_add_shared_arbiter.sv
// Directed bench for add_shared_arbiter (width=8, NumReq=4, speed=2) plus a
// random-traffic phase, and a combinational cross-check of every Add network
// at widths 13 and 32 against a behavioural sum.
module tb_add_shared_arbiter;

    localparam int W   = 8;
    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int SBW = IW + W;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] a_bus;
    logic [NR*W-1:0] b_bus;
    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    s_out;
    logic [IW-1:0]   res_id;
    logic            busy;

    int errors = 0;
    int checks = 0;

    // Scoreboard: {id, sum} for every accepted request, in acceptance order.
    logic [SBW-1:0] exp_q[$];

    // Previous-cycle samples for stability checks.
    logic [NR-1:0]   prev_valid  = '0;
    logic [NR-1:0]   prev_acc    = '0;
    logic [NR*W-1:0] prev_a      = '0;
    logic [NR*W-1:0] prev_b      = '0;
    logic            prev_rst    = 1'b1;
    logic            prev_rvalid = 1'b0;
    logic            prev_rready = 1'b0;
    logic [W-1:0]    prev_s      = '0;
    logic [IW-1:0]   prev_id     = '0;

    // Direct adder instances for network cross-checks.
    logic [12:0] a13, b13, s13_0, s13_1, s13_2;
    logic [31:0] a32, b32, s32_0, s32_1, s32_2;

    // Directed expectation tables.
    logic [3:0] exp_rdy [12];
    logic       exp_rv  [12];
    logic [7:0] exp_s   [12];
    logic [1:0] exp_id  [12];
    logic [7:0] op_a    [3];
    logic [7:0] op_b    [3];

    logic drained;

    add_shared_arbiter #(
        .width(W),
        .speed(2),
        .NumReq(NR)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .A_i(a_bus),
        .B_i(b_bus),
        .res_valid_o(res_valid),
        .res_ready_i(res_ready),
        .S_o(s_out),
        .res_id_o(res_id),
        .busy_o(busy)
    );

    Add #(.width(13), .speed(0)) u_add13_0 (.a(a13), .b(b13), .s(s13_0));
    Add #(.width(13), .speed(1)) u_add13_1 (.a(a13), .b(b13), .s(s13_1));
    Add #(.width(13), .speed(2)) u_add13_2 (.a(a13), .b(b13), .s(s13_2));
    Add #(.width(32), .speed(0)) u_add32_0 (.a(a32), .b(b32), .s(s32_0));
    Add #(.width(32), .speed(1)) u_add32_1 (.a(a32), .b(b32), .s(s32_1));
    Add #(.width(32), .speed(2)) u_add32_2 (.a(a32), .b(b32), .s(s32_2));

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] behavioural_Add(input logic [63:0] a,
                                                    input logic [63:0] b,
                                                    input int w);
        logic [63:0] full;
        full = a + b;
        if (w >= 64) return full;
        return full & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor, run at the falling edge while inputs are settled.
    task automatic monitor();
        logic [NR-1:0] acc;
        logic          ok;
        logic [SBW-1:0] e;
        acc = req_valid & req_ready;

        ok = $onehot0(req_ready) && ((req_ready & ~req_valid) == '0);
        check("ready_legal", 64'(ok), 64'd1);

        if (!prev_rst) begin
            ok = 1'b1;
            for (int r = 0; r < NR; r++) begin
                if (prev_valid[r] && !prev_acc[r]) begin
                    if (!req_valid[r] || (a_bus[r*W +: W] != prev_a[r*W +: W]) ||
                        (b_bus[r*W +: W] != prev_b[r*W +: W])) ok = 1'b0;
                end
            end
            check("req_stable", 64'(ok), 64'd1);
        end

        if (!prev_rst && prev_rvalid && !prev_rready) begin
            check("res_hold", 64'({res_valid, s_out, res_id}), 64'({1'b1, prev_s, prev_id}));
        end

        if (rst) begin
            exp_q.delete();
        end else begin
            if (res_valid && res_ready) begin
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_result", 64'({res_id, s_out}), 64'(e));
                end
            end
            for (int r = 0; r < NR; r++) begin
                if (acc[r]) exp_q.push_back({IW'(r), W'(a_bus[r*W +: W] + b_bus[r*W +: W])});
            end
        end

        prev_valid  = req_valid;
        prev_acc    = acc;
        prev_a      = a_bus;
        prev_b      = b_bus;
        prev_rst    = rst;
        prev_rvalid = res_valid;
        prev_rready = res_ready;
        prev_s      = s_out;
        prev_id     = res_id;
    endtask

    // Driver tasks
    task automatic look();
        @(negedge clk);
        monitor();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b);
        req_valid[r]   = 1'b1;
        a_bus[r*W +: W] = a;
        b_bus[r*W +: W] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        look();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_res(input string tag, input int c);
        check({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy[c]));
        check({tag, "_res_valid"}, 64'(res_valid), 64'(exp_rv[c]));
        if (exp_rv[c]) begin
            check({tag, "_sum"}, 64'(s_out), 64'(exp_s[c]));
            check({tag, "_id"}, 64'(res_id), 64'(exp_id[c]));
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        a_bus     = '0;
        b_bus     = '0;
        res_ready = 1'b0;
        a13 = '0; b13 = '0; a32 = '0; b32 = '0;

        // ---- Reset state ----
        do_reset();
        look();
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_sum", 64'(s_out), 64'd0);
        check("rst_id", 64'(res_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);

        // ---- Single request: requester 2, 0x7F + 0x01 ----
        tick();
        set_req(2, 8'h7F, 8'h01);
        res_ready = 1'b1;
        look();
        check("single_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid[2] = 1'b0;
        look();
        check("single_s1_res_valid", 64'(res_valid), 64'd0);
        check("single_s1_busy", 64'(busy), 64'd1);
        tick();
        look();
        check("single_res_valid", 64'(res_valid), 64'd1);
        check("single_sum", 64'(s_out), 64'h80);
        check("single_id", 64'(res_id), 64'd2);
        tick();
        look();
        check("single_after_valid", 64'(res_valid), 64'd0);
        check("single_after_busy", 64'(busy), 64'd0);
        tick();

        // ---- Fairness: all four valid, A=r, B=0x10 ----
        do_reset();
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
                    4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        exp_rv  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        exp_s   = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13,
                    8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h00};
        exp_id  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        res_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k < 6) begin
                for (int r = 0; r < NR; r++) set_req(r, 8'(r), 8'h10);
            end else begin
                for (int r = 0; r < NR; r++) if (prev_acc[r]) req_valid[r] = 1'b0;
            end
            look();
            check_res("fair", k);
            tick();
        end

        // ---- Backpressure: requesters 0 and 1 valid, res_ready low 6 cycles ----
        exp_rdy = '{4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                    4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        exp_rv  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        exp_s   = '{8'h00, 8'h00, 8'h35, 8'h35, 8'h35, 8'h35,
                    8'h35, 8'h23, 8'h35, 8'h23, 8'h00, 8'h00};
        exp_id  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        for (int c = 0; c < 11; c++) begin
            res_ready = (c >= 6);
            if (c < 6) begin
                set_req(0, 8'h21, 8'h02);
                set_req(1, 8'h30, 8'h05);
            end else begin
                for (int r = 0; r < NR; r++) if (prev_acc[r]) req_valid[r] = 1'b0;
            end
            look();
            check_res("bp", c);
            if (c == 5) check("bp_busy_full", 64'(busy), 64'd1);
            tick();
        end

        // ---- Wrap-around sums on requester 1 ----
        op_a    = '{8'hFF, 8'hFF, 8'h00};
        op_b    = '{8'h01, 8'hFF, 8'h00};
        exp_rdy = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                    4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        exp_rv  = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        exp_s   = '{8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_id  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        res_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) set_req(1, op_a[c], op_b[c]);
            else req_valid[1] = 1'b0;
            look();
            check_res("wrap", c);
            tick();
        end

        // ---- Reset mid-flight ----
        res_ready = 1'b0;
        set_req(2, 8'h05, 8'h06);
        set_req(3, 8'h07, 8'h08);
        look();
        check("mid_ready0", 64'(req_ready), 64'b0100);
        tick();
        req_valid[2] = 1'b0;
        look();
        check("mid_ready1", 64'(req_ready), 64'b1000);
        tick();
        req_valid[3] = 1'b0;
        look();
        check("mid_full_valid", 64'(res_valid), 64'd1);
        check("mid_full_sum", 64'(s_out), 64'h0B);
        check("mid_full_id", 64'(res_id), 64'd2);
        check("mid_full_busy", 64'(busy), 64'd1);
        tick();
        rst = 1'b1;
        look();
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        set_req(3, 8'h11, 8'h22);
        set_req(0, 8'h40, 8'h04);
        look();
        check("post_rst_res_valid", 64'(res_valid), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_sum", 64'(s_out), 64'd0);
        check("post_rst_id", 64'(res_id), 64'd0);
        check("post_rst_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid[0] = 1'b0;
        look();
        check("post_rst_ready2", 64'(req_ready), 64'b1000);
        check("post_rst_res_valid2", 64'(res_valid), 64'd0);
        tick();
        req_valid[3] = 1'b0;
        look();
        check("post_rst_r0_valid", 64'(res_valid), 64'd1);
        check("post_rst_r0_sum", 64'(s_out), 64'h44);
        check("post_rst_r0_id", 64'(res_id), 64'd0);
        tick();
        look();
        check("post_rst_r3_valid", 64'(res_valid), 64'd1);
        check("post_rst_r3_sum", 64'(s_out), 64'h33);
        check("post_rst_r3_id", 64'(res_id), 64'd3);
        tick();
        look();
        check("post_rst_idle_valid", 64'(res_valid), 64'd0);
        check("post_rst_idle_busy", 64'(busy), 64'd0);
        tick();

        // ---- Random traffic with random backpressure ----
        for (int n = 0; n < 600; n++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r] || prev_acc[r]) begin
                    req_valid[r]    = ($urandom_range(0, 2) != 0);
                    a_bus[r*W +: W] = 8'($urandom_range(0, 255));
                    b_bus[r*W +: W] = 8'($urandom_range(0, 255));
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            look();
            tick();
        end
        drained = 1'b0;
        for (int n = 0; n < 50 && !drained; n++) begin
            for (int r = 0; r < NR; r++) if (prev_acc[r]) req_valid[r] = 1'b0;
            res_ready = 1'b1;
            look();
            if (req_valid == '0 && !busy && exp_q.size() == 0) drained = 1'b1;
            tick();
        end
        check("drain_done", 64'(drained), 64'd1);

        // ---- Adder networks against the behavioural sum ----
        for (int v = 0; v < 300; v++) begin
            case (v)
                0: begin a13 = '1; b13 = 13'd1; a32 = '1; b32 = 32'd1; end
                1: begin a13 = '1; b13 = '1; a32 = '1; b32 = '1; end
                2: begin a13 = '0; b13 = '0; a32 = '0; b32 = '0; end
                3: begin a13 = 13'h0AAA; b13 = 13'h1555; a32 = 32'hAAAA_AAAA; b32 = 32'h5555_5556; end
                default: begin
                    a13 = 13'($urandom); b13 = 13'($urandom);
                    a32 = $urandom; b32 = $urandom;
                end
            endcase
            #1;
            check("add13_ripple", 64'(s13_0), behavioural_Add(64'(a13), 64'(b13), 13));
            check("add13_brent_kung", 64'(s13_1), behavioural_Add(64'(a13), 64'(b13), 13));
            check("add13_sklansky", 64'(s13_2), behavioural_Add(64'(a13), 64'(b13), 13));
            check("add32_ripple", 64'(s32_0), behavioural_Add(64'(a32), 64'(b32), 32));
            check("add32_brent_kung", 64'(s32_1), behavioural_Add(64'(a32), 64'(b32), 32));
            check("add32_sklansky", 64'(s32_2), behavioural_Add(64'(a32), 64'(b32), 32));
        end

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
